// File: rtl/mc_ctrl.sv
// Multicycle control sequencer: a Moore FSM stepping FETCH/DECODE/EXEC/MEM/WB with memory stalls.
// Optional memory-timeout watchdog enabled by defining MC_CTRL_TIMEOUT_EN.
module mc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] aluop,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [2:0] state,
  output logic       halted,
  output logic       err
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;

  localparam logic [3:0] OpLw   = 4'b1000;
  localparam logic [3:0] OpSw   = 4'b1001;
  localparam logic [3:0] OpBeq  = 4'b1010;
  localparam logic [3:0] OpJ    = 4'b1011;
  localparam logic [3:0] OpAddi = 4'b1100;
  localparam logic [3:0] OpNop1 = 4'b1101;
  localparam logic [3:0] OpNop2 = 4'b1110;
  localparam logic [3:0] OpHalt = 4'b1111;

  state_e state_q, state_d;
  logic   timeout;

`ifdef MC_CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
  logic       waiting;

  // Derived from registered state so the watchdog never loops through the output logic.
  assign waiting = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;

  always_comb begin
    wait_cnt_d = 8'd0;
    timeout    = 1'b0;
    if (waiting) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      timeout    = (wait_cnt_d >= 8'(TIMEOUT_CYCLES));
    end
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q & ~reset;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    aluop      = 3'b000;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        aluop     = AluAdd;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        alu_src_b = 2'b11;
        aluop     = AluAdd;
        case (opcode)
          OpJ: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = StFetch;
          end
          OpHalt:         state_d = StHalt;
          OpNop1, OpNop2: state_d = StFetch;
          default:        state_d = StExec;
        endcase
      end
      StExec: begin
        state_d = StFetch;
        if (!opcode[3]) begin
          alu_src_a = 1'b1;
          aluop     = opcode[2:0];
          state_d   = StWb;
        end else begin
          case (opcode)
            OpAddi, OpLw, OpSw: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              aluop     = AluAdd;
              state_d   = (opcode == OpAddi) ? StWb : StMem;
            end
            OpBeq: begin
              alu_src_a = 1'b1;
              aluop     = AluSub;
              pc_src    = 2'b01;
              pc_write  = zero;
            end
            default: ;
          endcase
        end
      end
      StMem: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OpSw);
        if (mem_ready) state_d = (opcode == OpLw) ? StWb : StFetch;
      end
      StWb: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OpLw);
        state_d    = StFetch;
      end
      StHalt:  halted = 1'b1;
      default: state_d = StFetch;
    endcase

    if (timeout) state_d = StHalt;

    // Reset silences every output, aborting any in-flight memory access.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      aluop      = 3'b000;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      halted     = 1'b0;
    end
  end

  assign state = reset ? 3'd0 : state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected output vectors queued then compared at negedge.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] aluop, state;
  logic       reg_write, mem_to_reg, halted, err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    string      tag;
    logic [19:0] v;
  } exp_t;
  exp_t sb_q[$];

  mc_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aluop      (aluop),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .state      (state),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {state, halted, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg, err};

  function automatic logic [19:0] ev(input logic [2:0] st, input logic hlt, input logic mreq,
                                     input logic we, input logic io, input logic irw,
                                     input logic pcw, input logic [1:0] pcs, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] aop,
                                     input logic rw, input logic m2r, input logic er);
    return {st, hlt, mreq, we, io, irw, pcw, pcs, sa, sb, aop, rw, m2r, er};
  endfunction

  task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
  endtask

  // One clock: queue the expectation, compare at negedge, return 1 after next posedge.
  task automatic cyc(input string tag, input logic [19:0] exp);
    exp_t e;
    sb_q.push_back('{tag: tag, v: exp});
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq(e.tag, obs, e.v);
    @(posedge clk);
    #1;
  endtask

  logic [19:0] f_rdy, f_wait, dec, dec_j, ex_r3, ex_imm, wb_alu, wb_mem;
  logic [19:0] mem_rd, mem_wr, beq1, beq0, halt_v, halt_err;

  initial begin
    f_rdy    = ev(3'd0, 0, 1, 0, 0, 1, 1, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0);
    f_wait   = ev(3'd0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b010, 0, 0, 0);
    dec      = ev(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b010, 0, 0, 0);
    dec_j    = ev(3'd1, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b11, 3'b010, 0, 0, 0);
    ex_r3    = ev(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b011, 0, 0, 0);
    ex_imm   = ev(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b010, 0, 0, 0);
    wb_alu   = ev(3'd4, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 0);
    wb_mem   = ev(3'd4, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 1, 0);
    mem_rd   = ev(3'd3, 0, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0);
    mem_wr   = ev(3'd3, 0, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0);
    beq1     = ev(3'd2, 0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0);
    beq0     = ev(3'd2, 0, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b110, 0, 0, 0);
    halt_v   = ev(3'd5, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0);
    halt_err = ev(3'd5, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 1);

    reset = 1'b1; opcode = 4'b0000; zero = 1'b0; mem_ready = 1'b0;
    cyc("reset_outputs", 20'h0);
    reset = 1'b0; mem_ready = 1'b1;

    opcode = 4'b0011;
    cyc("rt_fetch", f_rdy); cyc("rt_decode", dec); cyc("rt_exec", ex_r3); cyc("rt_wb", wb_alu);

    opcode = 4'b1100;
    cyc("addi_fetch", f_rdy); cyc("addi_decode", dec); cyc("addi_exec", ex_imm);
    cyc("addi_wb", wb_alu);

    opcode = 4'b1000;
    cyc("lw_fetch", f_rdy); cyc("lw_decode", dec); cyc("lw_exec", ex_imm);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("lw_mem_wait%0d", i), mem_rd);
    mem_ready = 1'b1;
    cyc("lw_mem_done", mem_rd); cyc("lw_wb", wb_mem);

    opcode = 4'b1001;
    cyc("sw_fetch", f_rdy); cyc("sw_decode", dec); cyc("sw_exec", ex_imm);
    cyc("sw_mem", mem_wr);

    opcode = 4'b1010; zero = 1'b1;
    cyc("beq1_fetch", f_rdy); cyc("beq1_decode", dec); cyc("beq1_exec", beq1);
    zero = 1'b0;
    cyc("beq0_fetch", f_rdy); cyc("beq0_decode", dec); cyc("beq0_exec", beq0);

    opcode = 4'b1011;
    cyc("j_fetch", f_rdy); cyc("j_decode", dec_j);

    opcode = 4'b1101;
    cyc("nop_fetch", f_rdy); cyc("nop_decode", dec);

    opcode = 4'b1111;
    cyc("halt_fetch", f_rdy); cyc("halt_decode", dec);
    for (int i = 0; i < 20; i++) cyc($sformatf("halt_hold%0d", i), halt_v);
    reset = 1'b1;
    cyc("halt_reset", 20'h0);
    reset = 1'b0;
    cyc("post_halt_fetch", f_rdy);

    opcode = 4'b1001;
    cyc("rsw_decode", dec); cyc("rsw_exec", ex_imm);
    mem_ready = 1'b0;
    cyc("rsw_mem_wait", mem_wr);
    reset = 1'b1;
    cyc("rsw_reset_zero", 20'h0);
    reset = 1'b0;
    cyc("rsw_after_reset", f_wait);

    reset = 1'b1;
    cyc("to_reset", 20'h0);
    reset = 1'b0;
`ifdef MC_CTRL_TIMEOUT_EN
    for (int i = 0; i < 16; i++) cyc($sformatf("to_wait%0d", i), f_wait);
    cyc("to_halt_err", halt_err);
    cyc("to_halt_hold", halt_err);
`else
    for (int i = 0; i < 100; i++) cyc($sformatf("no_to_wait%0d", i), f_wait);
    if (halt_err == 20'h0) $display("unreachable");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control sequencer for the 4-bit-opcode datapath. One Moore FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives the PC, IR, register-file and memory enables, and it generates the 3-bit `aluop` consumed by the ALU. Memory accesses use a req/ready handshake, so the controller stalls for variable-latency memory.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of wait cycles on a memory access (used only with `MC_CTRL_TIMEOUT_EN`).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 4: IR opcode field; valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe, qualified by `mem_req`.
- `iord` out 1: address source; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: IR load enable.
- `pc_write` out 1: PC load enable.
- `pc_src` out 2: next-PC source; 00 ALU result, 01 ALUOut, 10 jump target.
- `alu_src_a` out 1: A operand; 0 = PC, 1 = regA.
- `alu_src_b` out 2: B operand; 00 regB, 01 const 4, 10 imm, 11 imm<<2.
- `aluop` out 3: ALU operation.
- `reg_write` out 1: register-file write enable.
- `mem_to_reg` out 1: writeback source; 1 = MDR, 0 = ALUOut.
- `state` out 3: current state encoding.
- `halted` out 1: high while in HALT.
- `err` out 1: memory timeout flag, sticky until reset (only with `MC_CTRL_TIMEOUT_EN`).

## Operation
- **State encoding:** FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to FETCH on the next edge.
- **ALU encoding:** ADD = 010, SUB = 110.
- **Default outputs:** every output not listed for a state is 0.
- **Opcode map:**
  - 0000–0111: R-type, `aluop = opcode[2:0]`.
  - 1000 LW, 1001 SW, 1010 BEQ, 1011 J, 1100 ADDI, 1111 HALT.
  - 1101 and 1110 are NOPs.
- **FETCH:**
  - Drives `mem_req=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=01`, `aluop=ADD`.
  - While `mem_ready=0`: stay in FETCH.
  - When `mem_ready=1`: assert `ir_write=1` and `pc_write=1` (`pc_src=00`) that cycle, then go to DECODE.
- **DECODE:**
  - Drives `alu_src_a=0`, `alu_src_b=11`, `aluop=ADD` (branch target into ALUOut).
  - J: `pc_write=1`, `pc_src=10`, go to FETCH.
  - HALT: go to HALT.
  - NOP: go to FETCH.
  - All other opcodes: go to EXEC.
- **EXEC:**
  - R-type: `alu_src_a=1`, `alu_src_b=00`, `aluop=opcode[2:0]`, go to WB.
  - ADDI: `alu_src_a=1`, `alu_src_b=10`, ADD, go to WB.
  - LW/SW: `alu_src_a=1`, `alu_src_b=10`, ADD, go to MEM.
  - BEQ: `alu_src_a=1`, `alu_src_b=00`, SUB, `pc_src=01`, `pc_write=zero`, go to FETCH.
- **MEM:**
  - Drives `mem_req=1`, `iord=1`, `mem_we = (opcode==SW)`.
  - Stays in MEM until `mem_ready=1`.
  - On `mem_ready=1`: SW goes to FETCH, LW goes to WB.
- **WB:**
  - `reg_write=1`, `mem_to_reg = (opcode==LW)`, go to FETCH.
- **HALT:**
  - `halted=1`; all enables 0; stays in HALT until `reset`.

## Timing
- **Reset:**
  - `reset` high at an edge puts the FSM in FETCH and clears the timeout counter and `err`.
  - While `reset` is high, all outputs are forced to 0, including `mem_req` and `state`.
  - Reset asserted mid-MEM aborts the access: no write strobe appears in the cycle after reset.
- **Outputs:** combinational from the registered state, plus `mem_ready`, `zero` and `opcode` where listed. They are valid in the same cycle.
- **Latency with zero-wait memory** (`mem_ready` high on the first request cycle):
  - R-type/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - J: 2 cycles.
  - Each wait cycle adds 1.
- **Handshake:**
  - `mem_req` stays high and `iord`/`mem_we` stay stable until the cycle in which `mem_ready=1` is sampled.
  - `mem_ready` while `mem_req=0` is ignored.

## Configuration
- **Macro:** `MC_CTRL_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter counts consecutive cycles with `mem_req=1` and `mem_ready=0`; it clears on handshake completion or on leaving FETCH/MEM.
  - When the count reaches `TIMEOUT_CYCLES`, the FSM goes to HALT on the next edge and `err` is set, sticky until reset.
- **Undefined:**
  - No counter is built; `err` is tied to 0.
  - The FSM waits indefinitely on memory.

## Test plan
- **R-type, zero-wait:** reset, `mem_ready=1`, `opcode=0011`.
  - States FETCH→DECODE→EXEC→WB→FETCH.
  - `aluop=011` in EXEC; `reg_write=1`, `mem_to_reg=0` in WB.
- **LW with 3 wait states:** `mem_ready` low for 3 cycles in MEM.
  - MEM held 4 cycles with `mem_req=1`, `iord=1`, `mem_we=0`.
  - Then WB with `mem_to_reg=1`; total 8 cycles.
- **BEQ:** `opcode=1010`.
  - With `zero=1`: EXEC asserts `pc_write=1`, `pc_src=01`, `aluop=110`.
  - With `zero=0`: `pc_write=0`; back to FETCH either way.
- **J, NOP, HALT:**
  - J: `pc_write=1`, `pc_src=10` in DECODE.
  - NOP (1101): DECODE→FETCH with no enables.
  - HALT (1111): `halted=1`, `state=5` held for 20 cycles; reset returns to FETCH.
- **Reset mid-SW:** assert `reset` during MEM with `mem_ready=0`.
  - All outputs 0 while `reset` is high.
  - `state=0` after release; no `mem_we` pulse.
- **Timeout (`MC_CTRL_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`):** `mem_ready` held low in FETCH.
  - HALT entered after 16 wait cycles; `err=1` and `halted=1`.
  - Without the macro: still in FETCH after 100 cycles, `err=0`.
